mem_arbiter: RTL and testbench

Two-port round-robin arbiter placed in front of the memory controller, so that two requesters can share one controller/RAM pair. Each requester runs a simple hold-until-ack protocol. The arbiter then drives the controller's Valid/RW/Addr_in/Data_in handshake, which completes when Ready falls and then rises again. A watchdog aborts any transaction that the controller never accepts or never completes.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_if : requester and memory-controller signals of mem_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
);
  logic              r0_valid;
  logic              r0_rw;
  logic [AWIDTH-1:0] r0_addr;
  logic [DWIDTH-1:0] r0_wdata;
  logic              r0_ack;
  logic              r0_err;

  logic              r1_valid;
  logic              r1_rw;
  logic [AWIDTH-1:0] r1_addr;
  logic [DWIDTH-1:0] r1_wdata;
  logic              r1_ack;
  logic              r1_err;

  logic [DWIDTH-1:0] rdata;

  logic              mc_valid;
  logic              mc_rw;
  logic [AWIDTH-1:0] mc_addr;
  logic [DWIDTH-1:0] mc_wdata;
  logic [DWIDTH-1:0] mc_rdata;
  logic              mc_ready;

  // Arbiter view
  modport master (
    input  r0_valid, r0_rw, r0_addr, r0_wdata,
    input  r1_valid, r1_rw, r1_addr, r1_wdata,
    input  mc_rdata, mc_ready,
    output r0_ack, r0_err, r1_ack, r1_err, rdata,
    output mc_valid, mc_rw, mc_addr, mc_wdata
  );

  // Requesters plus controller view
  modport slave (
    output r0_valid, r0_rw, r0_addr, r0_wdata,
    output r1_valid, r1_rw, r1_addr, r1_wdata,
    output mc_rdata, mc_ready,
    input  r0_ack, r0_err, r1_ack, r1_err, rdata,
    input  mc_valid, mc_rw, mc_addr, mc_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : two-port round-robin arbiter in front of a Valid/Ready memory
//               controller, with a per-phase watchdog that aborts stuck handshakes
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input wire            clk,
  input wire            reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic [7:0]        r_cnt;
  logic              r_mc_valid;
  logic              r_mc_rw;
  logic [AWIDTH-1:0] r_mc_addr;
  logic [DWIDTH-1:0] r_mc_wdata;
  logic [DWIDTH-1:0] r_rdata;
  logic [1:0]        r_ack;
  logic [1:0]        r_err;

  state_t            w_state;
  logic              w_last_grant;
  logic              w_grant;
  logic [7:0]        w_cnt;
  logic              w_mc_valid;
  logic              w_mc_rw;
  logic [AWIDTH-1:0] w_mc_addr;
  logic [DWIDTH-1:0] w_mc_wdata;
  logic [DWIDTH-1:0] w_rdata;
  logic [1:0]        w_ack;
  logic [1:0]        w_err;

  logic              w_any_valid;
  logic              w_pick;
  logic              w_req_rw;
  logic [AWIDTH-1:0] w_req_addr;
  logic [DWIDTH-1:0] w_req_wdata;
  logic              w_timeout;
  logic [1:0]        w_sel;

  // On a tie the requester that was not served last wins; otherwise the lone
  // valid requester is taken.
  assign w_any_valid = bus.r0_valid | bus.r1_valid;
  assign w_pick      = (bus.r0_valid & bus.r1_valid) ? ~r_last_grant : ~bus.r0_valid;
  assign w_req_rw    = w_pick ? bus.r1_rw    : bus.r0_rw;
  assign w_req_addr  = w_pick ? bus.r1_addr  : bus.r0_addr;
  assign w_req_wdata = w_pick ? bus.r1_wdata : bus.r0_wdata;
  assign w_timeout   = (r_cnt == c_timeout);
  assign w_sel       = {r_grant, ~r_grant};

  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_grant      = r_grant;
    w_cnt        = r_cnt;
    w_mc_valid   = r_mc_valid;
    w_mc_rw      = r_mc_rw;
    w_mc_addr    = r_mc_addr;
    w_mc_wdata   = r_mc_wdata;
    w_rdata      = r_rdata;
    w_ack        = 2'b00;
    w_err        = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_grant      = w_pick;
          w_last_grant = w_pick;
          w_mc_rw      = w_req_rw;
          w_mc_addr    = w_req_addr;
          w_mc_wdata   = w_req_wdata;
          w_mc_valid   = 1'b1;
          w_cnt        = 8'd0;
          w_state      = S_REQ;
        end
      end

      S_REQ: begin
        if (!bus.mc_ready) begin
          w_cnt   = 8'd0;
          w_state = S_WAIT;
        end else if (w_timeout) begin
          w_mc_valid = 1'b0;
          w_ack      = w_sel;
          w_err      = w_sel;
          w_state    = S_DONE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      S_WAIT: begin
        if (bus.mc_ready) begin
          w_mc_valid = 1'b0;
          if (r_mc_rw) begin
            w_rdata = bus.mc_rdata;
          end
          w_ack   = w_sel;
          w_state = S_DONE;
        end else if (w_timeout) begin
          w_mc_valid = 1'b0;
          w_ack      = w_sel;
          w_err      = w_sel;
          w_state    = S_DONE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      // Guarantees a second mc_valid-low cycle before the next grant
      S_DONE: begin
        w_mc_valid = 1'b0;
        w_state    = S_IDLE;
      end

      default: begin
        w_mc_valid = 1'b0;
        w_state    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= 8'd0;
      r_mc_valid   <= 1'b0;
      r_mc_rw      <= 1'b0;
      r_mc_addr    <= '0;
      r_mc_wdata   <= '0;
      r_rdata      <= '0;
      r_ack        <= 2'b00;
      r_err        <= 2'b00;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_grant      <= w_grant;
      r_cnt        <= w_cnt;
      r_mc_valid   <= w_mc_valid;
      r_mc_rw      <= w_mc_rw;
      r_mc_addr    <= w_mc_addr;
      r_mc_wdata   <= w_mc_wdata;
      r_rdata      <= w_rdata;
      r_ack        <= w_ack;
      r_err        <= w_err;
    end
  end

  assign bus.r0_ack   = r_ack[0];
  assign bus.r1_ack   = r_ack[1];
  assign bus.r0_err   = r_err[0];
  assign bus.r1_err   = r_err[1];
  assign bus.rdata    = r_rdata;
  assign bus.mc_valid = r_mc_valid;
  assign bus.mc_rw    = r_mc_rw;
  assign bus.mc_addr  = r_mc_addr;
  assign bus.mc_wdata = r_mc_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed, table-driven bench for mem_arbiter with a small
//                  RAM controller model (latency, stall and hang modes)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Controller model: accepts by dropping Ready, returns it after a short latency.
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_RET} mst_t;
  mst_t        m_state;
  logic [3:0]  m_cnt;
  logic        stall;
  logic        hang;
  logic [31:0] mem [16];

  always @(posedge clk) begin
    if (!reset) begin
      bus.mc_ready <= 1'b1;
      bus.mc_rdata <= '0;
      m_state      <= M_IDLE;
      m_cnt        <= 4'd0;
    end else begin
      case (m_state)
        M_IDLE: if (bus.mc_valid && !stall) begin
          bus.mc_ready <= 1'b0;
          m_cnt        <= 4'd2;
          m_state      <= M_BUSY;
        end
        M_BUSY: if (m_cnt != 4'd0) begin
          m_cnt <= m_cnt - 4'd1;
        end else if (!hang) begin
          if (bus.mc_rw) bus.mc_rdata <= mem[bus.mc_addr[3:0]];
          else           mem[bus.mc_addr[3:0]] <= bus.mc_wdata;
          bus.mc_ready <= 1'b1;
          m_state      <= M_RET;
        end
        M_RET: if (!bus.mc_valid) m_state <= M_IDLE;
        default: m_state <= M_IDLE;
      endcase
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int edges);
    logic seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      tick();
      edges++;
      seen = (bus.mc_valid === 1'b1);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL grant_timeout: no mc_valid after %0d cycles", edges);
    end
  endtask

  task automatic wait_ack(output int cycles, output logic [1:0] acks, output logic [1:0] errs,
                          output logic held);
    logic seen;
    cycles = 0;
    held   = 1'b1;
    seen   = 1'b0;
    while (!seen && cycles < 60) begin
      tick();
      cycles++;
      seen = (bus.r0_ack === 1'b1) || (bus.r1_ack === 1'b1);
      if (!seen && bus.mc_valid !== 1'b1) held = 1'b0;
    end
    acks = {bus.r1_ack, bus.r0_ack};
    errs = {bus.r1_err, bus.r0_err};
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: no ack after %0d cycles", cycles);
    end
  endtask

  task automatic check_done(input string pfx, input logic who, input logic err,
                            input logic [31:0] exp_rd, input logic [1:0] acks,
                            input logic [1:0] errs, input logic held);
    logic [1:0] sel;
    sel = who ? 2'b10 : 2'b01;
    check($sformatf("%s_ack", pfx), 64'(acks), 64'(sel));
    check($sformatf("%s_err", pfx), 64'(errs), err ? 64'(sel) : 64'd0);
    check($sformatf("%s_rdata", pfx), 64'(bus.rdata), 64'(exp_rd));
    check($sformatf("%s_valid_drop", pfx), 64'(bus.mc_valid), 64'd0);
    check($sformatf("%s_valid_held", pfx), 64'(held), 64'd1);
  endtask

  task automatic set_r0(input logic v, input logic rw, input logic [15:0] a, input logic [31:0] d);
    bus.r0_valid = v; bus.r0_rw = rw; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic set_r1(input logic v, input logic rw, input logic [15:0] a, input logic [31:0] d);
    bus.r1_valid = v; bus.r1_rw = rw; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic        rw0;
    logic        rw1;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        who;
    logic [15:0] eaddr;
    logic        erw;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         edges;
    int         cycles;
    logic [1:0] acks;
    logic [1:0] errs;
    logic       held;

    // Round-robin history carries from one vector to the next (last_grant = r1 at entry).
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h3, 16'h0, 32'h11111111, 32'h0, 1'b0, 16'h3, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h4, 32'h0, 32'h22222222, 1'b1, 16'h4, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h3, 16'h4, 32'h0, 32'h0,        1'b0, 16'h3, 1'b1, 32'h11111111};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h4, 16'h3, 32'h0, 32'h0,        1'b1, 16'h3, 1'b1, 32'h11111111};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h4, 16'h3, 32'h0, 32'h0,        1'b0, 16'h4, 1'b1, 32'h22222222};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h6, 32'h0, 32'h33333333, 1'b1, 16'h6, 1'b0, 32'h22222222};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h7, 16'h6, 32'h44444444, 32'h0, 1'b0, 16'h7, 1'b0, 32'h22222222};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h2, 16'h6, 32'h0, 32'h0,        1'b1, 16'h6, 1'b1, 32'h33333333};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h7, 16'h0, 32'h0, 32'h0,        1'b0, 16'h7, 1'b1, 32'h44444444};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h7, 32'h0, 32'h0,        1'b1, 16'h7, 1'b1, 32'h44444444};

    stall = 1'b0;
    hang  = 1'b0;
    reset = 1'b0;
    set_r0(1'b1, 1'b0, 16'h0002, 32'hDEADBEEF);
    set_r1(1'b1, 1'b1, 16'h0002, 32'h0);

    // Reset held with both requesters pending
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_mc_valid", 64'(bus.mc_valid), 64'd0);
      check("rst_ack", 64'({bus.r1_ack, bus.r0_ack}), 64'd0);
      check("rst_err", 64'({bus.r1_err, bus.r0_err}), 64'd0);
      check("rst_rdata", 64'(bus.rdata), 64'd0);
      check("rst_mc_addr", 64'(bus.mc_addr), 64'd0);
      check("rst_mc_wdata", 64'(bus.mc_wdata), 64'd0);
      check("rst_mc_rw", 64'(bus.mc_rw), 64'd0);
    end
    reset = 1'b1;

    // r0 wins the first tie: write DEADBEEF to address 2
    wait_grant(edges);
    check("first_grant_latency", 64'(edges), 64'd1);
    check("wr_mc_addr", 64'(bus.mc_addr), 64'h2);
    check("wr_mc_rw", 64'(bus.mc_rw), 64'd0);
    check("wr_mc_wdata", 64'(bus.mc_wdata), 64'hDEADBEEF);
    wait_ack(cycles, acks, errs, held);
    check_done("wr", 1'b0, 1'b0, 32'h0, acks, errs, held);
    bus.r0_valid = 1'b0;

    // r1 has been waiting: read back address 2
    wait_grant(edges);
    check("rd_gap", 64'(edges >= 2), 64'd1);
    check("rd_mc_addr", 64'(bus.mc_addr), 64'h2);
    check("rd_mc_rw", 64'(bus.mc_rw), 64'd1);
    wait_ack(cycles, acks, errs, held);
    check_done("rd", 1'b1, 1'b0, 32'hDEADBEEF, acks, errs, held);
    bus.r1_valid = 1'b0;
    tick();
    tick();
    check("rdata_hold", 64'(bus.rdata), 64'hDEADBEEF);

    for (int i = 0; i < 10; i++) begin
      set_r0(vecs[i].v0, vecs[i].rw0, vecs[i].a0, vecs[i].d0);
      set_r1(vecs[i].v1, vecs[i].rw1, vecs[i].a1, vecs[i].d1);
      wait_grant(edges);
      check($sformatf("v%0d_grant_latency", i), 64'(edges), 64'd1);
      check($sformatf("v%0d_mc_addr", i), 64'(bus.mc_addr), 64'(vecs[i].eaddr));
      check($sformatf("v%0d_mc_rw", i), 64'(bus.mc_rw), 64'(vecs[i].erw));
      wait_ack(cycles, acks, errs, held);
      check_done($sformatf("v%0d", i), vecs[i].who, 1'b0, vecs[i].erd, acks, errs, held);
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      tick();
      tick();
    end

    // Both requesters continuously valid: strict alternation starting with r0
    set_r0(1'b1, 1'b0, 16'h0008, 32'h55555555);
    set_r1(1'b1, 1'b1, 16'h0008, 32'h0);
    for (int i = 0; i < 6; i++) begin
      wait_grant(edges);
      if (i > 0) check($sformatf("ct%0d_gap", i), 64'(edges >= 2), 64'd1);
      check($sformatf("ct%0d_mc_rw", i), 64'(bus.mc_rw), 64'(i % 2));
      wait_ack(cycles, acks, errs, held);
      if (i == 5) begin
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
      end
      check_done($sformatf("ct%0d", i), 1'(i % 2), 1'b0,
                 (i == 0) ? 32'h44444444 : 32'h55555555, acks, errs, held);
    end
    tick();
    tick();

    // Controller never accepts: Ready stays high, abort TIMEOUT+1 cycles after REQ entry
    stall = 1'b1;
    set_r0(1'b1, 1'b1, 16'h0002, 32'h0);
    wait_grant(edges);
    wait_ack(cycles, acks, errs, held);
    check("stall_cycles", 64'(cycles), 64'(TO + 1));
    check_done("stall", 1'b0, 1'b1, 32'h55555555, acks, errs, held);
    bus.r0_valid = 1'b0;
    stall = 1'b0;
    tick();
    tick();

    // Controller accepts but never completes: abort TIMEOUT+1 cycles after WAIT entry
    hang = 1'b1;
    set_r1(1'b1, 1'b1, 16'h0002, 32'h0);
    wait_grant(edges);
    wait_ack(cycles, acks, errs, held);
    check("hang_cycles", 64'(cycles), 64'(TO + 3));
    check_done("hang", 1'b1, 1'b1, 32'h55555555, acks, errs, held);
    bus.r1_valid = 1'b0;
    hang = 1'b0;
    tick();
    tick();
    tick();

    // Reset while in WAIT: no ack for the aborted write, re-presented request completes
    hang = 1'b1;
    set_r1(1'b1, 1'b0, 16'h000A, 32'h77777777);
    wait_grant(edges);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mrst_mc_valid", 64'(bus.mc_valid), 64'd0);
    check("mrst_ack", 64'({bus.r1_ack, bus.r0_ack}), 64'd0);
    check("mrst_err", 64'({bus.r1_err, bus.r0_err}), 64'd0);
    check("mrst_rdata", 64'(bus.rdata), 64'd0);
    check("mrst_mc_addr", 64'(bus.mc_addr), 64'd0);
    check("mrst_mc_wdata", 64'(bus.mc_wdata), 64'd0);
    hang  = 1'b0;
    reset = 1'b1;
    wait_grant(edges);
    check("re_grant_latency", 64'(edges), 64'd1);
    check("re_mc_addr", 64'(bus.mc_addr), 64'hA);
    wait_ack(cycles, acks, errs, held);
    check_done("re", 1'b1, 1'b0, 32'h0, acks, errs, held);
    bus.r1_valid = 1'b0;
    tick();
    tick();

    set_r0(1'b1, 1'b1, 16'h000A, 32'h0);
    wait_grant(edges);
    wait_ack(cycles, acks, errs, held);
    check_done("rb", 1'b0, 1'b0, 32'h77777777, acks, errs, held);
    bus.r0_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
